// File: rtl/song_pkg.sv
// Shared song definitions: player FSM states and note word layout.
// Latency: none, declarations and a pure helper function only.
// Backpressure: not applicable.
package song_pkg;

  // Player states, shared with the note ROM generator and the progress display.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_LOAD  = 3'd2,
    ST_PLAY  = 3'd3,
    ST_PAUSE = 3'd4,
    ST_DONE  = 3'd5
  } state_e;

  // Note word layout: pitch code in the upper byte, duration in beats in the lower byte.
  localparam int PITCH_MSB = 15;
  localparam int PITCH_LSB = 8;
  localparam int DUR_MSB   = 7;
  localparam int DUR_LSB   = 0;

  // A zero duration terminates the song.
  localparam logic [7:0] END_MARKER = 8'd0;

  typedef struct packed {
    logic [PITCH_MSB-PITCH_LSB:0] pitch;
    logic [DUR_MSB-DUR_LSB:0]     dur;
  } note_t;

  // Beat counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/beat_timer.sv
// Beat timer: tick down-counter that reloads each beat, plus the articulation-gap compare.
// Latency: zero flag is combinational on the current count; gap flag reflects the count after the next edge.
// Backpressure: none; freeze holds the count for as long as it is asserted.
module beat_timer #(
  parameter logic [23:0] TICKS_PER_BEAT = 24'd6_250_000,
  parameter logic [23:0] GAP_TICKS      = 24'd500_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic load,
  input  logic en,
  input  logic freeze,
  output logic zero,
  output logic gap_next
);

  logic [23:0] tick_cnt;
  logic [23:0] tick_nxt;
  logic        counting;

  assign counting = en && !freeze;

  // Next count: clear beats reload, reload beats counting; a beat boundary restarts the count.
  always_comb begin
    tick_nxt = tick_cnt;
    if (clr) begin
      tick_nxt = '0;
    end else if (load) begin
      tick_nxt = TICKS_PER_BEAT - 24'd1;
    end else if (counting) begin
      tick_nxt = (tick_cnt == '0) ? TICKS_PER_BEAT - 24'd1 : tick_cnt - 24'd1;
    end
  end

  assign zero     = counting && (tick_cnt == '0);
  assign gap_next = (tick_nxt < GAP_TICKS);

  // Tick counter state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_nxt;
    end
  end

endmodule

// File: rtl/song_sequencer.sv
// Song sequencer: walks a note ROM at a fixed tempo and drives play/pause/done status.
// Latency: start pulse to sounding note is 3 cycles; every output is registered.
// Backpressure: none; button pulses arriving in states that do not accept them are dropped.
module song_sequencer
  import song_pkg::*;
#(
  parameter logic [23:0] TICKS_PER_BEAT = 24'd6_250_000,
  parameter logic [23:0] GAP_TICKS      = 24'd500_000,
  parameter int          ADDR_W         = 8,
  parameter logic [7:0]  SONG_LEN       = 8'd255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              btn_play,
  input  logic              btn_reset,
  output logic [ADDR_W-1:0] note_addr,
  input  logic [15:0]       note_data,
  output logic [7:0]        note_pitch,
  output logic              note_on,
  output logic              play,
  output logic              song_done,
  output logic              reset_player,
  output logic              beat_tick,
  output logic [15:0]       beats_elapsed
);

  localparam logic [2:0] S_IDLE  = ST_IDLE;
  localparam logic [2:0] S_FETCH = ST_FETCH;
  localparam logic [2:0] S_LOAD  = ST_LOAD;
  localparam logic [2:0] S_PLAY  = ST_PLAY;
  localparam logic [2:0] S_PAUSE = ST_PAUSE;
  localparam logic [2:0] S_DONE  = ST_DONE;

  logic [2:0]        state, state_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic [7:0]        pitch_nxt;
  logic [7:0]        dur_cnt, dur_nxt;
  logic [15:0]       beats_nxt;
  logic              rp_nxt, bt_nxt, on_nxt;
  logic              tmr_clr, tmr_load, tmr_en, tmr_freeze, tmr_zero, tmr_gap;
  note_t             word;

  assign word = note_data;

  // The timer only runs in PLAY; a play press that cycle pauses without consuming a tick.
  assign tmr_en     = (state == S_PLAY) && !btn_reset;
  assign tmr_freeze = btn_play;

  beat_timer #(
    .TICKS_PER_BEAT(TICKS_PER_BEAT),
    .GAP_TICKS     (GAP_TICKS)
  ) u_beat_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (tmr_clr),
    .load    (tmr_load),
    .en      (tmr_en),
    .freeze  (tmr_freeze),
    .zero    (tmr_zero),
    .gap_next(tmr_gap)
  );

  // Player FSM and next values of everything it owns; btn_reset overrides any state.
  always_comb begin
    state_nxt = state;
    addr_nxt  = note_addr;
    pitch_nxt = note_pitch;
    dur_nxt   = dur_cnt;
    beats_nxt = beats_elapsed;
    rp_nxt    = 1'b0;
    bt_nxt    = 1'b0;
    tmr_clr   = 1'b0;
    tmr_load  = 1'b0;
    if (btn_reset) begin
      state_nxt = S_IDLE;
      addr_nxt  = '0;
      pitch_nxt = '0;
      dur_nxt   = '0;
      beats_nxt = '0;
      rp_nxt    = 1'b1;
      tmr_clr   = 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          if (btn_play) begin
            state_nxt = S_FETCH;
            addr_nxt  = '0;
            beats_nxt = '0;
          end
        end
        S_FETCH: state_nxt = S_LOAD;
        S_LOAD: begin
          if ((word.dur == END_MARKER) || (note_addr == ADDR_W'(SONG_LEN))) begin
            state_nxt = S_DONE;
          end else begin
            state_nxt = S_PLAY;
            pitch_nxt = word.pitch;
            dur_nxt   = word.dur;
            tmr_load  = 1'b1;
          end
        end
        S_PLAY: begin
          if (btn_play) begin
            state_nxt = S_PAUSE;
          end else if (tmr_zero) begin
            bt_nxt    = 1'b1;
            beats_nxt = sat_inc16(beats_elapsed);
            dur_nxt   = dur_cnt - 8'd1;
            if (dur_cnt == 8'd1) begin
              addr_nxt  = note_addr + ADDR_W'(1);
              state_nxt = S_FETCH;
            end
          end
        end
        S_PAUSE: begin
          if (btn_play) state_nxt = S_PLAY;
        end
        S_DONE: begin
          if (btn_play) begin
            rp_nxt    = 1'b1;
            addr_nxt  = '0;
            beats_nxt = '0;
            state_nxt = S_FETCH;
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // note_on is judged on post-edge counters so the gap lands on the last GAP_TICKS of the note.
  assign on_nxt = (state_nxt == S_PLAY) && !((dur_nxt == 8'd1) && tmr_gap);

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= S_IDLE;
      note_addr     <= '0;
      note_pitch    <= '0;
      dur_cnt       <= '0;
      beats_elapsed <= '0;
      note_on       <= 1'b0;
      play          <= 1'b0;
      song_done     <= 1'b0;
      reset_player  <= 1'b0;
      beat_tick     <= 1'b0;
    end else begin
      state         <= state_nxt;
      note_addr     <= addr_nxt;
      note_pitch    <= pitch_nxt;
      dur_cnt       <= dur_nxt;
      beats_elapsed <= beats_nxt;
      note_on       <= on_nxt;
      play          <= (state_nxt == S_PLAY);
      song_done     <= (state_nxt == S_DONE);
      reset_player  <= rp_nxt;
      beat_tick     <= bt_nxt;
    end
  end

endmodule

// File: tb/tb_song_sequencer.sv
// Bench for song_sequencer: directed scenarios plus random button traffic against a reference model.
// Latency: outputs sampled on the falling edge after each rising edge.
// Backpressure: not applicable.
module tb_song_sequencer;

  localparam int T       = 4;
  localparam int G       = 1;
  localparam int M_IDLE  = 0;
  localparam int M_FETCH = 1;
  localparam int M_LOAD  = 2;
  localparam int M_PLAY  = 3;
  localparam int M_PAUSE = 4;
  localparam int M_DONE  = 5;

  logic        clk, rst, btn_play, btn_reset;
  logic [7:0]  note_addr, note_pitch;
  logic [15:0] note_data, beats_elapsed;
  logic        note_on, play, song_done, reset_player, beat_tick;

  logic [7:0]  addr1, pitch1;
  logic [15:0] data1, beats1;
  logic        on1, play1, done1, rp1, bt1;

  logic [15:0] rom [256];

  int tests = 0;
  int fails = 0;

  // Reference model: position inside the current note counted up in cycles.
  int m_mode, m_idx, m_k, m_dur, m_pitch, m_beats;
  bit m_rp, m_bt;

  song_sequencer #(
    .TICKS_PER_BEAT(24'd4), .GAP_TICKS(24'd1), .ADDR_W(8), .SONG_LEN(8'd255)
  ) dut (
    .clk(clk), .rst(rst), .btn_play(btn_play), .btn_reset(btn_reset),
    .note_addr(note_addr), .note_data(note_data), .note_pitch(note_pitch),
    .note_on(note_on), .play(play), .song_done(song_done),
    .reset_player(reset_player), .beat_tick(beat_tick), .beats_elapsed(beats_elapsed)
  );

  song_sequencer #(
    .TICKS_PER_BEAT(24'd4), .GAP_TICKS(24'd1), .ADDR_W(8), .SONG_LEN(8'd1)
  ) dut1 (
    .clk(clk), .rst(rst), .btn_play(btn_play), .btn_reset(btn_reset),
    .note_addr(addr1), .note_data(data1), .note_pitch(pitch1),
    .note_on(on1), .play(play1), .song_done(done1),
    .reset_player(rp1), .beat_tick(bt1), .beats_elapsed(beats1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Synchronous note ROMs: data valid one cycle after the address.
  always @(posedge clk) begin
    note_data <= rom[note_addr];
    data1     <= rom[addr1];
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE; m_idx = 0; m_k = 0; m_dur = 0; m_pitch = 0; m_beats = 0;
    m_rp = 0; m_bt = 0;
  endtask

  task automatic model_step(input logic bp, input logic br);
    logic [15:0] w;
    m_rp = 0;
    m_bt = 0;
    if (br) begin
      model_reset();
      m_rp = 1;
    end else begin
      case (m_mode)
        M_IDLE:  if (bp) begin m_mode = M_FETCH; m_idx = 0; m_beats = 0; end
        M_FETCH: m_mode = M_LOAD;
        M_LOAD: begin
          w = rom[m_idx];
          if (w[7:0] == 8'd0 || m_idx == 255) m_mode = M_DONE;
          else begin
            m_mode = M_PLAY; m_pitch = int'(w[15:8]); m_dur = int'(w[7:0]); m_k = 0;
          end
        end
        M_PLAY: begin
          if (bp) m_mode = M_PAUSE;
          else begin
            m_k++;
            if (m_k % T == 0) begin
              m_bt = 1;
              if (m_beats < 65535) m_beats++;
            end
            if (m_k == m_dur * T) begin
              m_idx  = (m_idx + 1) % 256;
              m_mode = M_FETCH;
            end
          end
        end
        M_PAUSE: if (bp) m_mode = M_PLAY;
        M_DONE:  if (bp) begin m_rp = 1; m_idx = 0; m_beats = 0; m_mode = M_FETCH; end
        default: m_mode = M_IDLE;
      endcase
    end
  endtask

  task automatic compare_all();
    chk("note_addr", note_addr, m_idx);
    chk("note_pitch", note_pitch, m_pitch);
    chk("note_on", note_on, (m_mode == M_PLAY) && (m_k < m_dur * T - G));
    chk("play", play, m_mode == M_PLAY);
    chk("song_done", song_done, m_mode == M_DONE);
    chk("reset_player", reset_player, m_rp);
    chk("beat_tick", beat_tick, m_bt);
    chk("beats_elapsed", beats_elapsed, m_beats);
  endtask

  // One clock: buttons held across the rising edge, outputs checked on the falling edge.
  task automatic cycle(input logic bp, input logic br);
    btn_play  = bp;
    btn_reset = br;
    @(posedge clk);
    model_step(bp, br);
    #1;
    btn_play  = 1'b0;
    btn_reset = 1'b0;
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    int first_on, on0, on_40, nticks, done_at, saw40, bad, end_r;
    rst = 1'b0; btn_play = 1'b0; btn_reset = 1'b0;
    for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
    rom[0] = 16'h3C02; rom[1] = 16'h4001; rom[2] = 16'h0000;
    model_reset();
    repeat (2) @(negedge clk);
    compare_all();
    rst = 1'b1;
    cycle(1'b0, 1'b0);

    // Full song from cycle 0.
    first_on = -1; on0 = 0; on_40 = 0; nticks = 0; done_at = -1; saw40 = 0;
    cycle(1'b1, 1'b0);
    for (int c = 1; c <= 21; c++) begin
      if (note_on && first_on < 0) first_on = c;
      if (note_on && note_pitch == 8'h3C) on0++;
      if (note_on && note_pitch == 8'h40) on_40++;
      if (beat_tick) nticks++;
      if (song_done && done_at < 0) done_at = c;
      if (pitch1 == 8'h40 || on1 && addr1 != 8'd0) saw40 = 1;
      cycle(1'b0, 1'b0);
    end
    chk("song_first_on", first_on, 3);
    chk("song_note0_on_len", on0, 7);
    chk("song_note1_on_len", on_40, 3);
    chk("song_beat_ticks", nticks, 3);
    chk("song_done_cycle", done_at, 19);
    chk("song_done_beats", beats_elapsed, 3);
    chk("len1_done", done1, 1);
    chk("len1_beats", beats1, 2);
    chk("len1_no_note1", saw40, 0);

    // Restart from DONE, then pause five cycles into note 0.
    cycle(1'b1, 1'b0);
    chk("restart_rp", reset_player, 1);
    chk("restart_beats", beats_elapsed, 0);
    cycle(1'b0, 1'b0);
    chk("restart_rp_one_cycle", reset_player, 0);
    chk("restart_not_on_r2", note_on, 0);
    cycle(1'b0, 1'b0);
    chk("restart_on_r3", note_on, 1);
    chk("restart_pitch", note_pitch, 8'h3C);
    repeat (5) cycle(1'b0, 1'b0);
    cycle(1'b1, 1'b0);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (play || note_on || beats_elapsed != 16'd1) bad++;
      cycle(1'b0, 1'b0);
    end
    if (play || note_on || beats_elapsed != 16'd1) bad++;
    chk("pause_quiet", bad, 0);
    cycle(1'b1, 1'b0);
    end_r = -1;
    for (int r = 30; r < 70 && end_r < 0; r++) begin
      if (note_addr == 8'd1) end_r = r;
      else cycle(1'b0, 1'b0);
    end
    chk("pause_note0_end", end_r, 11 + 22);

    // btn_reset during note 1.
    for (int i = 0; i < 10 && !(play && note_addr == 8'd1); i++) cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b0);
    chk("midsong_in_note1", play, 1);
    cycle(1'b0, 1'b1);
    chk("midsong_rp", reset_player, 1);
    chk("midsong_addr", note_addr, 0);
    chk("midsong_note_on", note_on, 0);
    chk("midsong_play", play, 0);
    cycle(1'b0, 1'b0);
    chk("midsong_rp_one_cycle", reset_player, 0);

    // btn_play during FETCH is dropped.
    cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b0);
    cycle(1'b0, 1'b0);
    chk("fetch_press_play", play, 1);
    cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b0);
    chk("fetch_press_no_pause", play, 1);

    // btn_reset and btn_play together in PLAY: IDLE, not PAUSE.
    cycle(1'b1, 1'b1);
    chk("collide_rp", reset_player, 1);
    chk("collide_play", play, 0);
    cycle(1'b0, 1'b0);
    cycle(1'b1, 1'b0);
    chk("collide_idle_not_pause", play, 0);
    cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b0);
    chk("collide_restart_play", play, 1);

    // Asynchronous rst mid-note.
    cycle(1'b0, 1'b0);
    #2 rst = 1'b0;
    #1;
    model_reset();
    chk("rst_play", play, 0);
    chk("rst_note_on", note_on, 0);
    chk("rst_rp", reset_player, 0);
    chk("rst_addr", note_addr, 0);
    chk("rst_pitch", note_pitch, 0);
    chk("rst_beats", beats_elapsed, 0);
    @(negedge clk);
    rst = 1'b1;
    cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b0);

    // Random songs and random button traffic.
    for (int s = 0; s < 3; s++) begin
      cycle(1'b0, 1'b1);
      for (int i = 0; i < 8; i++) rom[i] = {8'($urandom_range(1, 255)), 8'($urandom_range(1, 3))};
      rom[8] = {8'($urandom_range(0, 255)), 8'h00};
      for (int n = 0; n < 600; n++)
        cycle($urandom_range(0, 11) == 0, $urandom_range(0, 149) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
